// File: rtl/cla_nibble_sched_pkg.sv
// ============================================================================
// cla_nibble_sched_pkg : shared constants for the nibble-serial CLA scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_nibble_sched_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Nibble counter width; a single-nibble operand still needs one bit.
  function automatic int cnt_w(input int nibs);
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_nibble_sched_cla4_slice.sv
// ============================================================================
// cla4_slice : 4-bit carry-lookahead adder slice, fully expanded carries
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4_slice
  import cla_nibble_sched_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[NIB_W-1:0];
  assign cout = w_c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/cla_nibble_sched.sv
// ============================================================================
// cla_nibble_sched : two-requester round-robin front end that sequences a
//                    shared 4-bit CLA slice nibble by nibble over WIDTH bits
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble_sched
  import cla_nibble_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int             NIBS   = WIDTH / NIB_W;
  localparam int             K_W    = cnt_w(NIBS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NIBS - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_ptr;
  logic             r_id;
  logic             r_carry;
  logic [K_W-1:0]   r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_slice_sum;
  logic             w_slice_cout;

  // Pointer high means requester 1 wins a tie.
  assign w_grant1 = req1_valid & (~req0_valid | r_ptr);
  assign w_grant0 = req0_valid & ~w_grant1;
  assign w_accept = (r_state == IDLE) & (req0_valid | req1_valid);

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (r_k == K_W'(i)) begin
        w_a_nib = r_a[i*NIB_W +: NIB_W];
        w_b_nib = r_b[i*NIB_W +: NIB_W];
      end
    end
  end

  cla4_slice u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req0_valid | req1_valid) w_next = RUN;
      RUN:     if (r_k == K_LAST)           w_next = DONE;
      DONE:    if (res_ready)               w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    if (r_state == IDLE) begin
      req0_ready = w_grant0;
      req1_ready = w_grant1;
    end
    if (r_state == DONE) res_valid = 1'b1;
    if (r_state != IDLE) busy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= w_grant1 ? req1_a   : req0_a;
      r_b     <= w_grant1 ? req1_b   : req0_b;
      r_carry <= w_grant1 ? req1_cin : req0_cin;
      r_id    <= w_grant1;
      r_ptr   <= ~w_grant1;
      r_k     <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      for (int i = 0; i < NIBS; i++) begin
        if (r_k == K_W'(i)) r_sum[i*NIB_W +: NIB_W] <= w_slice_sum;
      end
      r_carry <= w_slice_cout;
      r_k     <= r_k + K_W'(1);
    end
  end

  assign res_sum  = r_sum;
  assign res_cout = r_carry;
  assign res_id   = r_id;

endmodule

`default_nettype wire
